// File: rtl/aes_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_pkg : shared constants and types for the AES-128 round ctrl  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package aes_pkg;

   localparam int BUS_WIDTH  = 128;
   localparam int NUM_ROUNDS = 10;
   localparam int RND_IDX_W  = $clog2(NUM_ROUNDS + 1);

   typedef logic [RND_IDX_W-1:0] rnd_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_wait_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_wait_timer : loadable down-counter with zero flag            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module aes_wait_timer #(
   parameter int RND_LAT = 3
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Load,
   input  logic Dec,
   output logic Zero
);

   localparam int CNT_W = (RND_LAT > 1) ? $clog2(RND_LAT) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RND_LAT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Saturates at zero so a stale count can never wrap into a false capture.
   always_comb begin
      cnt_d = cnt_q;
      if (Load)
         cnt_d = LOAD_VAL;
      else if (Dec && (cnt_q != '0))
         cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign Zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | aes_round_ctrl : sequencer for the iterative AES-128 datapath.   |
// | Optional macro AES_RND_CTRL_ABORT_EN adds the Abort input.       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module aes_round_ctrl
   import aes_pkg::ctrl_state_e, aes_pkg::ST_IDLE, aes_pkg::ST_ISSUE,
          aes_pkg::ST_WAIT, aes_pkg::ST_DONE;
#(
   parameter int BUS_WIDTH  = aes_pkg::BUS_WIDTH,
   parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
   parameter int RND_LAT    = 3
) (
   input  logic                              Clk,
   input  logic                              Rst,
`ifdef AES_RND_CTRL_ABORT_EN
   input  logic                              Abort,
`endif
   input  logic                              In_Valid,
   output logic                              In_Ready,
   input  logic [BUS_WIDTH-1:0]              In_Data,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   Rk_Idx,
   input  logic [BUS_WIDTH-1:0]              Rk_Data,
   output logic                              Rnd_Start,
   output logic [BUS_WIDTH-1:0]              Rnd_Data,
   output logic                              Last_Round,
   input  logic [BUS_WIDTH-1:0]              Rnd_Result,
   output logic                              Out_Valid,
   input  logic                              Out_Ready,
   output logic [BUS_WIDTH-1:0]              Out_Data
);

   localparam int IDX_W = $clog2(NUM_ROUNDS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

   ctrl_state_e            state_q, state_d;
   logic [IDX_W-1:0]       round_q, round_d;
   logic [BUS_WIDTH-1:0]   data_q, data_d;
   logic                   timer_load;
   logic                   timer_zero;
   logic                   abort;
   logic                   in_round;

`ifdef AES_RND_CTRL_ABORT_EN
   assign abort = Abort;
`else
   assign abort = 1'b0;
`endif

   aes_wait_timer #(
      .RND_LAT (RND_LAT)
   ) u_wait_timer (
      .Clk  (Clk),
      .Rst  (Rst),
      .Load (timer_load),
      .Dec  (state_q == ST_WAIT),
      .Zero (timer_zero)
   );

   always_comb begin
      state_d    = state_q;
      round_d    = round_q;
      data_d     = data_q;
      timer_load = 1'b0;
      if (abort) begin
         state_d = ST_IDLE;
         round_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Initial AddRoundKey: Rk_Idx is 0 here, so Rk_Data is key 0.
               if (In_Valid) begin
                  data_d  = In_Data ^ Rk_Data;
                  round_d = IDX_W'(1);
                  state_d = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               timer_load = 1'b1;
               state_d    = ST_WAIT;
            end
            ST_WAIT: begin
               if (timer_zero) begin
                  data_d = Rnd_Result;
                  if (round_q == LAST_IDX) begin
                     state_d = ST_DONE;
                  end else begin
                     round_d = round_q + IDX_W'(1);
                     state_d = ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               if (Out_Ready) begin
                  round_d = '0;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               round_d = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= ST_IDLE;
         round_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         round_q <= round_d;
         data_q  <= data_d;
      end
   end

   assign in_round   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign In_Ready   = (state_q == ST_IDLE) && !abort;
   assign Rnd_Start  = (state_q == ST_ISSUE);
   assign Rk_Idx     = in_round ? round_q : '0;
   assign Last_Round = in_round && (round_q == LAST_IDX);
   assign Rnd_Data   = data_q;
   assign Out_Valid  = (state_q == ST_DONE);
   assign Out_Data   = data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_aes_round_ctrl : bench with golden AES-128 datapath and keys  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_aes_round_ctrl;

   localparam int BW  = 128;
   localparam int NR  = 10;
   localparam int LAT = 3;
   localparam int OUT_LAT = 1 + NR * (LAT + 1);

   localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          In_Valid, In_Ready, Rnd_Start, Last_Round, Out_Valid, Out_Ready;
   logic [BW-1:0] In_Data, Rk_Data, Rnd_Data, Rnd_Result, Out_Data;
   logic [3:0]    Rk_Idx;
`ifdef AES_RND_CTRL_ABORT_EN
   logic          Abort;
`endif

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   aes_round_ctrl #(.BUS_WIDTH(BW), .NUM_ROUNDS(NR), .RND_LAT(LAT)) dut (
      .Clk        (Clk),
      .Rst        (Rst),
`ifdef AES_RND_CTRL_ABORT_EN
      .Abort      (Abort),
`endif
      .In_Valid   (In_Valid),
      .In_Ready   (In_Ready),
      .In_Data    (In_Data),
      .Rk_Idx     (Rk_Idx),
      .Rk_Data    (Rk_Data),
      .Rnd_Start  (Rnd_Start),
      .Rnd_Data   (Rnd_Data),
      .Last_Round (Last_Round),
      .Rnd_Result (Rnd_Result),
      .Out_Valid  (Out_Valid),
      .Out_Ready  (Out_Ready),
      .Out_Data   (Out_Data)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // ---------------- AES-128 golden model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00; x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [15:0] d;
      d = {x, x};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv, x;
         x   = 8'(a);
         inv = (a == 0) ? 8'h00 : 8'h01;
         if (a != 0) for (int k = 0; k < 254; k++) inv = gmul(inv, x);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   b  [16];
      logic [7:0]   sr [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) b[i] = sb[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) sr[4*c+r] = b[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
         if (last) begin
            for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = sr[4*c+r];
         end else begin
            o[127-32*c -: 8] = gmul(sr[4*c],8'h02) ^ gmul(sr[4*c+1],8'h03) ^ sr[4*c+2] ^ sr[4*c+3];
            o[119-32*c -: 8] = sr[4*c] ^ gmul(sr[4*c+1],8'h02) ^ gmul(sr[4*c+2],8'h03) ^ sr[4*c+3];
            o[111-32*c -: 8] = sr[4*c] ^ sr[4*c+1] ^ gmul(sr[4*c+2],8'h02) ^ gmul(sr[4*c+3],8'h03);
            o[103-32*c -: 8] = gmul(sr[4*c],8'h03) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul(sr[4*c+3],8'h02);
         end
      end
      return o ^ k;
   endfunction

   function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ round_key(key, 0);
      for (int r = 1; r <= NR; r++) s = aes_round(s, round_key(key, r), r == NR);
      return s;
   endfunction

   // ---------------- key schedule and datapath models ----------------
   logic [127:0] rk_tab [0:NR];
   assign Rk_Data = (int'(Rk_Idx) <= NR) ? rk_tab[Rk_Idx] : '0;

   task automatic set_key(input logic [127:0] key);
      for (int r = 0; r <= NR; r++) rk_tab[r] = round_key(key, r);
   endtask

   // Result is only meaningful exactly LAT cycles after Rnd_Start; noise otherwise.
   logic [127:0] pipe [LAT];
   always @(posedge Clk) begin
      pipe[0] <= Rnd_Start ? aes_round(Rnd_Data, Rk_Data, Last_Round)
                           : {$urandom, $urandom, $urandom, $urandom};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign Rnd_Result = pipe[LAT-1];

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      n_total++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   int           st_cyc[$];
   int           st_idx[$];
   int           st_lr[$];
   bit           lr_bad, hold_bad, ir_bad, acc_ok;
   int           lat, acc_idx;
   logic [127:0] ct;

   task automatic clear_mon();
      st_cyc.delete(); st_idx.delete(); st_lr.delete();
      lr_bad = 0; hold_bad = 0; ir_bad = 0; lat = -1; ct = '0; acc_idx = -1;
   endtask

   // Leaves the bench at the negedge of the accept cycle.
   task automatic accept(input logic [127:0] pt);
      int n;
      @(negedge Clk);
      In_Valid = 1'b1; In_Data = pt;
      n = 0;
      while (!In_Ready && n < 100) begin @(negedge Clk); n++; end
      acc_ok = In_Ready;
      if (!acc_ok) begin timeout("accept"); In_Valid = 1'b0; end
      acc_idx = int'(Rk_Idx);
   endtask

   task automatic collect(input int rdy_dly, input bit keep_valid, input logic [127:0] next_pt);
      int n;
      @(negedge Clk);
      if (keep_valid) In_Data = next_pt; else In_Valid = 1'b0;
      n = 1;
      while (!Out_Valid && n < 200) begin
         if (Rnd_Start) begin
            st_cyc.push_back(n); st_idx.push_back(int'(Rk_Idx)); st_lr.push_back(int'(Last_Round));
         end
         if (Last_Round && int'(Rk_Idx) != NR) lr_bad = 1;
         if (In_Ready) ir_bad = 1;
         @(negedge Clk); n++;
      end
      if (!Out_Valid) begin timeout("out_valid"); return; end
      lat = n; ct = Out_Data;
      repeat (rdy_dly) begin
         @(negedge Clk);
         if (Out_Data !== ct || !Out_Valid) hold_bad = 1;
         if (In_Ready) ir_bad = 1;
      end
      Out_Ready = 1'b1;
      if (In_Ready) ir_bad = 1;
      @(negedge Clk);
      Out_Ready = 1'b0;
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input int rdy_dly);
      clear_mon();
      set_key(key);
      accept(pt);
      if (acc_ok) collect(rdy_dly, 1'b0, '0);
   endtask

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      int           rdy_dly;
   } vec_t;

   vec_t vt [3];

   // ---------------- main sequence ----------------
   initial begin
      logic [127:0] k, p, pb, outs [2];
      int acc_c [2];
      int got, acc, n;
      bit sw, ov_seen;

      In_Valid = 1'b0; In_Data = '0; Out_Ready = 1'b0;
`ifdef AES_RND_CTRL_ABORT_EN
      Abort = 1'b0;
`endif
      build_sbox();
      set_key(K1);

      vt[0] = '{K1, P1, C1, 0};
      vt[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 2};
      vt[2] = '{128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 5};

      repeat (3) @(negedge Clk);
      check("rst_in_ready",   In_Ready,   1'b1);
      check("rst_rnd_start",  Rnd_Start,  1'b0);
      check("rst_out_valid",  Out_Valid,  1'b0);
      check("rst_last_round", Last_Round, 1'b0);
      check("rst_rk_idx",     Rk_Idx,     4'd0);
      check("rst_out_data",   Out_Data,   '0);
      check("rst_rnd_data",   Rnd_Data,   '0);
      Rst = 1'b1;

      // Known-answer vectors; the first one also checks round sequencing.
      for (int v = 0; v < 3; v++) begin
         run_block(vt[v].key, vt[v].pt, vt[v].rdy_dly);
         check($sformatf("vec%0d_ct", v), ct, vt[v].ct);
         check($sformatf("vec%0d_lat", v), lat, OUT_LAT);
         check($sformatf("vec%0d_hold", v), hold_bad, 1'b0);
         if (v == 0) begin
            check("seq_idx_at_accept", acc_idx, 0);
            check("seq_num_starts", st_cyc.size(), NR);
            for (int i = 0; i < st_cyc.size(); i++) begin
               check($sformatf("seq_start%0d_cycle", i), st_cyc[i], 1 + i * (LAT + 1));
               check($sformatf("seq_start%0d_idx", i), st_idx[i], i + 1);
               check($sformatf("seq_start%0d_last", i), st_lr[i], (i == NR - 1) ? 1 : 0);
            end
            check("seq_last_round_only_r10", lr_bad, 1'b0);
            check("seq_in_ready_busy", ir_bad, 1'b0);
         end
      end

      // Backpressure: Out_Ready low 7 cycles while the next block is already offered.
      pb = 128'hfedcba9876543210_0123456789abcdef;
      clear_mon();
      set_key(K1);
      accept(P1);
      if (acc_ok) begin
         collect(7, 1'b1, pb);
         check("bp_ct", ct, C1);
         check("bp_out_hold", hold_bad, 1'b0);
         check("bp_in_ready_low", ir_bad, 1'b0);
         check("bp_in_ready_after", In_Ready, 1'b1);
         clear_mon();
         collect(0, 1'b0, '0);
         check("bp_second_ct", ct, aes_encrypt(K1, pb));
         check("bp_second_lat", lat, OUT_LAT);
      end

      // Back-to-back with Out_Ready tied high.
      set_key(K1);
      got = 0; acc = 0; n = 0; sw = 0;
      @(negedge Clk);
      In_Valid = 1'b1; In_Data = P1; Out_Ready = 1'b1;
      while (got < 2 && n < 300) begin
         if (In_Valid && In_Ready && acc < 2) begin acc_c[acc] = cyc; acc++; sw = 1; end
         if (Out_Valid && Out_Ready) begin outs[got] = Out_Data; got++; end
         @(negedge Clk); n++;
         if (sw) begin
            sw = 0;
            In_Data = pb;
            if (acc == 2) In_Valid = 1'b0;
         end
      end
      Out_Ready = 1'b0;
      if (got < 2) timeout("b2b_outputs");
      else begin
         check("b2b_accept_spacing", acc_c[1] - acc_c[0], NR * (LAT + 1) + 2);
         check("b2b_ct0", outs[0], C1);
         check("b2b_ct1", outs[1], aes_encrypt(K1, pb));
      end

      // Reset asserted during round 5.
      clear_mon();
      set_key(K1);
      accept(P1);
      n = 0;
      @(negedge Clk); In_Valid = 1'b0;
      while (!(Rnd_Start && Rk_Idx == 4'd5) && n < 100) begin @(negedge Clk); n++; end
      if (n >= 100) timeout("rst_round5");
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      check("mrst_in_ready",   In_Ready,   1'b1);
      check("mrst_rnd_start",  Rnd_Start,  1'b0);
      check("mrst_out_valid",  Out_Valid,  1'b0);
      check("mrst_last_round", Last_Round, 1'b0);
      check("mrst_rk_idx",     Rk_Idx,     4'd0);
      check("mrst_out_data",   Out_Data,   '0);
      check("mrst_rnd_data",   Rnd_Data,   '0);
      @(negedge Clk); Rst = 1'b1;
      @(negedge Clk);
      check("mrst_in_ready_release", In_Ready, 1'b1);
      run_block(K1, pb, 1);
      check("mrst_next_ct", ct, aes_encrypt(K1, pb));
      check("mrst_next_lat", lat, OUT_LAT);

`ifdef AES_RND_CTRL_ABORT_EN
      // Abort wins over acceptance in IDLE.
      @(negedge Clk);
      Abort = 1'b1; In_Valid = 1'b1; In_Data = P1;
      check("abort_idle_in_ready", In_Ready, 1'b0);
      @(negedge Clk);
      Abort = 1'b0; In_Valid = 1'b0;
      check("abort_idle_no_start", Rnd_Start, 1'b0);
      check("abort_idle_still_idle", In_Ready, 1'b1);
      // Abort in WAIT of round 3.
      clear_mon();
      set_key(K1);
      accept(P1);
      n = 0;
      @(negedge Clk); In_Valid = 1'b0;
      while (!(Rnd_Start && Rk_Idx == 4'd3) && n < 100) begin @(negedge Clk); n++; end
      if (n >= 100) timeout("abort_round3");
      @(negedge Clk);
      Abort = 1'b1;
      @(negedge Clk);
      Abort = 1'b0;
      check("abort_idle_next", In_Ready, 1'b1);
      check("abort_rk_idx", Rk_Idx, 4'd0);
      ov_seen = 0;
      repeat (50) begin @(negedge Clk); if (Out_Valid) ov_seen = 1; end
      check("abort_no_out_valid", ov_seen, 1'b0);
      run_block(K1, P1, 0);
      check("abort_next_ct", ct, C1);
`endif

      // Randomised blocks against the reference model.
      for (int i = 0; i < 5; i++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         run_block(k, p, int'($urandom_range(0, 3)));
         check($sformatf("rand%0d_ct", i), ct, aes_encrypt(k, p));
         check($sformatf("rand%0d_lat", i), lat, OUT_LAT);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencing controller for the iterative AES-128 encryption datapath. It accepts one 128-bit block over a valid/ready handshake and performs the initial AddRoundKey locally. It then drives the external round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey) once per round. Each round it presents the round index to the key schedule, waits the datapath's fixed pipeline latency and captures the result. After the last round it holds the ciphertext until the output handshake completes.

## Interface
- BUS_WIDTH, 128, block/state width in bits
- NUM_ROUNDS, 10, number of cipher rounds (AES-128)
- RND_LAT, 3, cycles from Rnd_Start to Rnd_Result valid; must be ≥ 1
- Clk  input  1  clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- In_Valid  input  1  plaintext block offered
- In_Ready  output  1  controller can accept a block
- In_Data  input  BUS_WIDTH  plaintext
- Rk_Idx  output  $clog2(NUM_ROUNDS+1)  round-key index to key schedule
- Rk_Data  input  BUS_WIDTH  round key for Rk_Idx, combinational same cycle
- Rnd_Start  output  1  one-cycle pulse launching a round in the datapath
- Rnd_Data  output  BUS_WIDTH  current state to datapath
- Last_Round  output  1  current round is NUM_ROUNDS (datapath bypasses MixColumns)
- Rnd_Result  input  BUS_WIDTH  datapath output, valid RND_LAT cycles after Rnd_Start
- Out_Valid  output  1  ciphertext available
- Out_Ready  input  1  consumer accepts ciphertext
- Out_Data  output  BUS_WIDTH  ciphertext

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - In_Ready=1 and Rk_Idx=0.
  - On In_Valid: state_reg ← In_Data ^ Rk_Data, round ← 1, next state ISSUE.
- ISSUE:
  - Rnd_Start=1 for one cycle; wait counter ← RND_LAT-1; next state WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter is 0, state_reg ← Rnd_Result.
  - If round==NUM_ROUNDS, next state is DONE. Otherwise round increments and the next state is ISSUE.
- DONE:
  - Out_Valid=1 and Out_Data=state_reg.
  - On Out_Ready, next state is IDLE.
- Rk_Idx=round and Last_Round=(round==NUM_ROUNDS) in ISSUE and WAIT. Both are stable from Rnd_Start through capture.
- Rnd_Data=state_reg at all times. It is unchanged between issue and capture.
- Round counter width is $clog2(NUM_ROUNDS+1). It never exceeds NUM_ROUNDS; it is reset to 0 on return to IDLE.
- The In_Data handshake is honoured only in IDLE. In_Valid in other states is ignored and not lost: the producer holds it.
- No same-cycle output-accept and new-input-accept: In_Ready rises the cycle after the Out_Ready handshake.
- Out_Data is held stable while Out_Valid=1 and Out_Ready=0.

## Timing
- Reset values:
  - State IDLE, so In_Ready=1.
  - Rnd_Start=0, Out_Valid=0, Last_Round=0.
  - Rk_Idx=0, Out_Data=0, Rnd_Data=0.
- Input accepted at edge ending cycle T → first Rnd_Start in cycle T+1.
- Each round takes RND_LAT+1 cycles.
- Out_Valid first high in cycle T+1+NUM_ROUNDS·(RND_LAT+1). With defaults this is T+41.
- Minimum accept-to-accept interval is NUM_ROUNDS·(RND_LAT+1)+2 cycles when Out_Ready is tied high.
- Reset asserted mid-operation: immediate return to IDLE with reset values. The in-flight block is discarded and the datapath result is ignored.

## Configuration
- AES_RND_CTRL_ABORT_EN defined:
  - Adds input port Abort (1 bit).
  - Abort high in any state forces IDLE at the next edge. Round is cleared, Out_Valid drops, no output is produced.
  - Abort has priority over In_Valid acceptance in IDLE: nothing is accepted that cycle.
- AES_RND_CTRL_ABORT_EN undefined: no Abort port; a block always runs to completion.

## Structure
- Shared package aes_pkg:
  - BUS_WIDTH and NUM_ROUNDS constants.
  - Round-index typedef.
  - Controller state enum (IDLE, ISSUE, WAIT, DONE).
- Sub-module aes_wait_timer: loadable down-counter with a zero flag, RND_LAT-parameterised.
- The FSM, round counter and state register stay in aes_round_ctrl.

## Test plan
- FIPS-197 vector, with a golden round-datapath model and key schedule in the bench:
  - Key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff.
  - Required: Out_Data=69c4e0d86a7b0430d8cdb78070b4c55a, with Out_Valid first high 41 cycles after the accept.
- Round sequencing:
  - Required: Rk_Idx sequence 0,1..10.
  - Required: exactly 10 Rnd_Start pulses spaced 4 cycles apart.
  - Required: Last_Round high only during round 10.
- Backpressure:
  - Stimulus: Out_Ready held low 7 cycles after Out_Valid, with In_Valid held high throughout.
  - Required: Out_Data stable; In_Ready=0 until the cycle after the Out_Ready handshake, then the second block is accepted.
- Back-to-back:
  - Stimulus: two blocks with Out_Ready tied high.
  - Required: accepts 42 cycles apart, and both ciphertexts are correct.
- Reset mid-run:
  - Stimulus: Rst low during round 5.
  - Required: all outputs at reset values, In_Ready=1 after release, and the next block is correct.
- With AES_RND_CTRL_ABORT_EN:
  - Stimulus: Abort in WAIT of round 3.
  - Required: IDLE next cycle, no Out_Valid pulse, and the following block is correct.
